// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Handshaked data-memory target. Accepts one load/store at a time
//             on a valid/ready request channel, waits WAIT_STATES cycles,
//             then performs the access and returns read data or a write
//             acknowledgement (plus an access-fault flag) on a valid/ready
//             response channel.
//  Ports    : i_clk        clock, rising edge
//             i_rst        asynchronous reset, active low
//             i_req_valid  request present
//             o_req_ready  responder can accept (IDLE and out of reset)
//             i_req_we     1 = store, 0 = load
//             i_req_addr   byte address
//             i_req_wdata  store data, little-endian byte lanes
//             i_req_wstrb  store byte enables (ignored for loads)
//             o_rsp_valid  response present (registered)
//             i_rsp_ready  initiator consumes the response
//             o_rsp_rdata  load data; 0 for stores and faults (registered)
//             o_rsp_err    access fault: out of range or misaligned
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int MEM_SIZE    = 4096,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2,
    parameter int BASE_ADDR   = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [DATA_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_wstrb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err
);

    localparam int C_BYTES = DATA_WIDTH / 8;
    localparam int C_WORDS = MEM_SIZE / C_BYTES;
    localparam int C_LSB   = (C_BYTES > 1) ? $clog2(C_BYTES) : 0;
    localparam int C_IDX_W = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;

    localparam logic [DATA_WIDTH-1:0] C_BASE       = DATA_WIDTH'(BASE_ADDR);
    localparam logic [DATA_WIDTH-1:0] C_SIZE       = DATA_WIDTH'(MEM_SIZE);
    localparam logic [DATA_WIDTH-1:0] C_ALIGN_MASK = DATA_WIDTH'(C_BYTES - 1);
    localparam logic [3:0]            C_WAIT_LOAD  = 4'(WAIT_STATES);
    localparam logic                  C_ZERO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [C_BYTES-1:0]    r_wstrb;

    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    logic [DATA_WIDTH-1:0] r_mem [C_WORDS];

    logic                  w_accept;
    logic                  w_access;
    logic                  w_acc_we;
    logic [DATA_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_wdata;
    logic [C_BYTES-1:0]    w_acc_wstrb;
    logic [DATA_WIDTH-1:0] w_off;
    logic [C_IDX_W-1:0]    w_idx;
    logic                  w_fault;

    // Ready depends only on registered state, masked while reset is held.
    assign o_req_ready = (r_state == S_IDLE) && i_rst;

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

    // With zero wait states the access happens on the acceptance edge, so
    // the operands come straight from the request port; otherwise from the
    // latched copy.
    assign w_acc_we    = (r_state == S_IDLE) ? i_req_we    : r_we;
    assign w_acc_addr  = (r_state == S_IDLE) ? i_req_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? i_req_wdata : r_wdata;
    assign w_acc_wstrb = (r_state == S_IDLE) ? i_req_wstrb : r_wstrb;

    // Offset wraps modulo 2^DATA_WIDTH; the explicit below-base test catches
    // the wrapped case.
    assign w_off   = w_acc_addr - C_BASE;
    assign w_idx   = C_IDX_W'(w_off >> C_LSB);
    assign w_fault = (w_acc_addr < C_BASE) ||
                     (w_off >= C_SIZE)     ||
                     ((w_acc_addr & C_ALIGN_MASK) != '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = i_req_valid && o_req_ready;
                if (w_accept) begin
                    if (C_ZERO_WAIT) begin
                        w_state_nxt = S_RESP;
                        w_access    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_RESP;
                    w_access    = 1'b1;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, request latch, counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_wstrb <= i_req_wstrb;
                r_cnt   <= C_WAIT_LOAD;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_fault;
                r_rsp_rdata <= (!w_fault && !w_acc_we) ? r_mem[w_idx] : '0;
            end else if ((r_state == S_RESP) && i_rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Backing store, not reset. Writes happen only on the access edge, which
    // cannot occur while reset holds the FSM in IDLE, so a store caught in
    // WAIT by reset is never committed.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (w_access && w_acc_we && !w_fault) begin
            for (int b = 0; b < C_BYTES; b++) begin
                if (w_acc_wstrb[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_acc_wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder (default parameters).
//             Table of directed load/store vectors plus hand-written
//             back-pressure and mid-transaction reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int WS = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_cmp;
    int n_err;

    dmem_responder #(
        .MEM_SIZE   (4096),
        .DATA_WIDTH (32),
        .WAIT_STATES(WS),
        .BASE_ADDR  (0)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_we   (req_we),
        .i_req_addr (req_addr),
        .i_req_wdata(req_wdata),
        .i_req_wstrb(req_wstrb),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata),
        .o_rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and complete its response. Called #1 after an edge.
    task automatic run_txn(input string nm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [31:0] exp_rdata, input logic exp_err);
        int waited;
        int lat;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk({nm, " req_ready"}, {31'd0, req_ready}, 32'd1);
        tick();                         // acceptance edge
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        // Response cycle index, counting the acceptance cycle as cycle 0.
        chk({nm, " latency"}, 32'(lat + 1), 32'(WS + 1));
        chk({nm, " rdata"}, rsp_rdata, exp_rdata);
        chk({nm, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({nm, " valid cleared"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, " rdata cleared"}, rsp_rdata, 32'd0);
        chk({nm, " ready after"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_rdata;
        logic        held_err;
        int          lat;
        int          extra;

        n_cmp = 0;
        n_err = 0;

        //           we    addr           wdata          wstrb  exp_rdata     err
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0FFC, 32'h55AA_55AA, 4'hF, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h55AA_55AA, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 32'h0,        1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'hF, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h0,        1'b0};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
        vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 32'h0,        1'b0};
        vecs[15] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};

        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("reset req_ready", {31'd0, req_ready}, 32'd0);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err",   {31'd0, rsp_err},   32'd0);
        rst = 1'b1;
        tick();
        chk("post-reset req_ready", {31'd0, req_ready}, 32'd1);

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].wstrb, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Back-pressure: response held for 5 cycles with a request pending.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        tick();                         // acceptance edge (IDLE, ready=1)
        req_addr  = 32'h20;             // keep a different request pending
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp latency", 32'(lat + 1), 32'(WS + 1));
        chk("bp rdata", rsp_rdata, 32'hDEAD_AAEF);
        held_rdata = rsp_rdata;
        held_err   = rsp_err;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp hold%0d valid", c), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp hold%0d rdata", c), rsp_rdata, held_rdata);
            chk($sformatf("bp hold%0d err", c), {31'd0, rsp_err}, {31'd0, held_err});
            chk($sformatf("bp hold%0d req_ready", c), {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();                         // handshake edge
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp handshake valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp back in idle", {31'd0, req_ready}, 32'd1);
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (rsp_valid) extra++;
        end
        chk("bp single response", 32'(extra), 32'd0);

        // Reset while a store is waiting: the store must be dropped.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1111_1111;
        req_wstrb = 4'hF;
        tick();                         // acceptance edge
        req_valid = 1'b0;
        tick();                         // one cycle after acceptance
        rst = 1'b0;
        #1;
        chk("rst mid rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst mid rsp_rdata", rsp_rdata, 32'd0);
        chk("rst mid rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst mid req_ready", {31'd0, req_ready}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst release req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        chk("rst release rsp_valid", {31'd0, rsp_valid}, 32'd0);
        run_txn("after-reset load", 1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
